// File: rtl/mux_41_if.sv
// Bus bundle for mux_41: four data inputs, selector and capture strobe in, registered result out.
// z_comb exists only when MUX41_COMB_OUT_EN is defined.
interface mux_41_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic [WIDTH-1:0] i3;
   logic [WIDTH-1:0] i4;
   logic [1:0]       sel;
   logic             in_valid;
   logic [WIDTH-1:0] z;
   logic [1:0]       sel_q;
   logic             out_valid;
`ifdef MUX41_COMB_OUT_EN
   logic [WIDTH-1:0] z_comb;

   modport master (
      output i1, i2, i3, i4, sel, in_valid,
      input  z, sel_q, out_valid, z_comb
   );

   modport slave (
      input  i1, i2, i3, i4, sel, in_valid,
      output z, sel_q, out_valid, z_comb
   );
`else
   modport master (
      output i1, i2, i3, i4, sel, in_valid,
      input  z, sel_q, out_valid
   );

   modport slave (
      input  i1, i2, i3, i4, sel, in_valid,
      output z, sel_q, out_valid
   );
`endif
endinterface

// File: rtl/mux_41.sv
// Purpose: registered 4:1 mux of WIDTH-bit buses; MUX41_COMB_OUT_EN adds a combinational z_comb tap.
// Latency: 1 clock from in_valid to z/sel_q/out_valid; one result per cycle when in_valid is held high.
// Backpressure: none; every in_valid beat is captured, and z/sel_q hold between beats.
module mux_41 #(
   parameter int WIDTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   mux_41_if.slave   bus
);

   logic [WIDTH-1:0] sel_dat;

   always_comb begin
      sel_dat = bus.i1;
      case (bus.sel)
         2'b00:   sel_dat = bus.i1;
         2'b01:   sel_dat = bus.i2;
         2'b10:   sel_dat = bus.i3;
         default: sel_dat = bus.i4;
      endcase
   end

   // Reset wins over a same-cycle capture, so that beat is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.z         <= '0;
         bus.sel_q     <= 2'b00;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.z     <= sel_dat;
            bus.sel_q <= bus.sel;
         end
      end
   end

`ifdef MUX41_COMB_OUT_EN
   assign bus.z_comb = sel_dat;
`endif

endmodule

// File: tb/tb_mux_41.sv
// Directed and randomised checks of mux_41: reset, selector sweep, hold, random stream, reset mid-stream.
module tb_mux_41;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mux_41_if #(.WIDTH(4)) bus ();

   mux_41 #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle 1 time unit past it before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.i1       = 4'($urandom);
      bus.i2       = 4'($urandom);
      bus.i3       = 4'($urandom);
      bus.i4       = 4'($urandom);
      bus.sel      = 2'($urandom);
      step();
      bus.sel      = 2'($urandom);
      bus.i4       = 4'($urandom);
      step();
      total++;
      if (bus.z !== 4'h0) begin
         bad++;
         $display("FAIL reset_z: got %h want 0", bus.z);
      end
      total++;
      if (bus.sel_q !== 2'b00) begin
         bad++;
         $display("FAIL reset_sel_q: got %0d want 0", bus.sel_q);
      end
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_sweep();
      logic [3:0] exp_z [4];
      exp_z[0] = 4'h3;
      exp_z[1] = 4'hA;
      exp_z[2] = 4'h5;
      exp_z[3] = 4'hC;
      bus.i1       = 4'h3;
      bus.i2       = 4'hA;
      bus.i3       = 4'h5;
      bus.i4       = 4'hC;
      bus.in_valid = 1'b1;
      for (int s = 0; s < 4; s++) begin
         bus.sel = 2'(s);
         step();
         total++;
         if (bus.z !== exp_z[s]) begin
            bad++;
            $display("FAIL sweep_z sel=%0d: got %h want %h", s, bus.z, exp_z[s]);
         end
         total++;
         if (bus.sel_q !== 2'(s)) begin
            bad++;
            $display("FAIL sweep_sel_q sel=%0d: got %0d want %0d", s, bus.sel_q, s);
         end
         total++;
         if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL sweep_out_valid sel=%0d: got %b want 1", s, bus.out_valid);
         end
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_hold();
      bus.sel      = 2'd2;
      bus.i1       = 4'h1;
      bus.i2       = 4'h2;
      bus.i3       = 4'h9;
      bus.i4       = 4'h4;
      bus.in_valid = 1'b1;
      step();
      total++;
      if (bus.z !== 4'h9 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL hold_capture: got z=%h vld=%b want z=9 vld=1", bus.z, bus.out_valid);
      end
      bus.in_valid = 1'b0;
      bus.i1       = 4'hF;
      bus.i2       = 4'hF;
      bus.i3       = 4'hF;
      bus.i4       = 4'hF;
      bus.sel      = 2'd3;
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (bus.z !== 4'h9) begin
            bad++;
            $display("FAIL hold_z cycle=%0d: got %h want 9", k, bus.z);
         end
         total++;
         if (bus.sel_q !== 2'd2) begin
            bad++;
            $display("FAIL hold_sel_q cycle=%0d: got %0d want 2", k, bus.sel_q);
         end
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_out_valid cycle=%0d: got %b want 0", k, bus.out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] held_z;
      logic [1:0] held_sel;
      logic       vld;
      held_z   = 4'h9;
      held_sel = 2'd2;
      for (int n = 0; n < 1000; n++) begin
         bus.i1       = 4'($urandom);
         bus.i2       = 4'($urandom);
         bus.i3       = 4'($urandom);
         bus.i4       = 4'($urandom);
         bus.sel      = 2'($urandom);
         vld          = 1'($urandom);
         bus.in_valid = vld;
         if (vld) begin
            case (bus.sel)
               2'd0:    held_z = bus.i1;
               2'd1:    held_z = bus.i2;
               2'd2:    held_z = bus.i3;
               default: held_z = bus.i4;
            endcase
            held_sel = bus.sel;
         end
         step();
         total++;
         if (bus.out_valid !== vld) begin
            bad++;
            $display("FAIL random_out_valid n=%0d: got %b want %b", n, bus.out_valid, vld);
         end
         total++;
         if (bus.z !== held_z || bus.sel_q !== held_sel) begin
            bad++;
            $display("FAIL random_z n=%0d: got z=%h sel_q=%0d want z=%h sel_q=%0d",
                     n, bus.z, bus.sel_q, held_z, held_sel);
         end
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      bus.sel      = 2'd3;
      bus.i1       = 4'h0;
      bus.i2       = 4'h0;
      bus.i3       = 4'h0;
      bus.i4       = 4'h7;
      bus.in_valid = 1'b1;
      step();
      total++;
      if (bus.z !== 4'h7) begin
         bad++;
         $display("FAIL midrst_precapture: got %h want 7", bus.z);
      end
      rst = 1'b1;
      step();
      total++;
      if (bus.z !== 4'h0) begin
         bad++;
         $display("FAIL midrst_z: got %h want 0", bus.z);
      end
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid);
      end
      total++;
      if (bus.sel_q !== 2'd0) begin
         bad++;
         $display("FAIL midrst_sel_q: got %0d want 0", bus.sel_q);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      step();
   endtask

`ifdef MUX41_COMB_OUT_EN
   task automatic test_comb();
      bus.i1       = 4'h1;
      bus.i2       = 4'hB;
      bus.i3       = 4'h3;
      bus.i4       = 4'h4;
      bus.sel      = 2'd1;
      bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.z_comb !== 4'hB) begin
         bad++;
         $display("FAIL comb_same_cycle: got %h want b", bus.z_comb);
      end
      total++;
      if (bus.z !== 4'h0) begin
         bad++;
         $display("FAIL comb_z_before_edge: got %h want 0", bus.z);
      end
      step();
      total++;
      if (bus.z !== 4'hB) begin
         bad++;
         $display("FAIL comb_z_after_edge: got %h want b", bus.z);
      end
      bus.in_valid = 1'b0;
      bus.sel      = 2'd3;
      #1;
      total++;
      if (bus.z_comb !== 4'h4) begin
         bad++;
         $display("FAIL comb_no_valid: got %h want 4", bus.z_comb);
      end
      step();
   endtask
`endif

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.sel      = 2'd0;
      bus.i1       = 4'h0;
      bus.i2       = 4'h0;
      bus.i3       = 4'h0;
      bus.i4       = 4'h0;
      test_reset();
      test_sweep();
      test_hold();
      test_random();
      test_reset_mid();
`ifdef MUX41_COMB_OUT_EN
      test_comb();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_41.md
Name: mux_41

Overview:
- Registered 4-to-1 multiplexer for WIDTH-bit data buses.
- Selects one of four input vectors with a 2-bit selector and presents the result on a registered output one clock later.
- Used as a generic datapath steering element wherever a clean, glitch-free, clock-aligned selected value is needed.

Parameters:
- WIDTH, 4, bit width of each data input and of the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i1  input  WIDTH  data input 0, selected when sel=2'b00.
- i2  input  WIDTH  data input 1, selected when sel=2'b01.
- i3  input  WIDTH  data input 2, selected when sel=2'b10.
- i4  input  WIDTH  data input 3, selected when sel=2'b11.
- sel  input  2  selector.
- in_valid  input  1  qualifies i1..i4 and sel for capture this cycle.
- z  output  WIDTH  registered selected data.
- sel_q  output  2  selector value that produced the current z.
- out_valid  output  1  high for one cycle per captured input.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on a rising clk edge with rst=1, the block drives z=0, sel_q=2'b00 and out_valid=0. Reset overrides in_valid.
- Capture: on a rising edge with rst=0 and in_valid=1:
  - z <= input chosen by sel (00→i1, 01→i2, 10→i3, 11→i4).
  - sel_q <= sel.
  - out_valid <= 1.
- Latency: exactly 1 clock from the in_valid edge to z/out_valid.
- Hold: on a rising edge with rst=0 and in_valid=0, z and sel_q keep their values and out_valid <= 0.
- Back-to-back: in_valid high on consecutive cycles gives one result per cycle, with no bubbles.
- Selector values:
  - sel is fully decoded; no illegal values exist.
  - X/Z on sel is not handled specially; the bench drives only known values.
- No combinational path from any input to z, sel_q or out_valid unless the optional feature is enabled.
- Width: the output width equals WIDTH. No extension or truncation is applied.
- Reset mid-stream: a capture requested in the same cycle as rst=1 is discarded. out_valid is 0 on the following cycle.

Optional Feature:
- Macro: MUX41_COMB_OUT_EN.
- Defined:
  - Adds output port z_comb [WIDTH]. It is a purely combinational 4:1 selection of i1..i4 by sel, independent of clk, rst and in_valid.
  - Registered behaviour is unchanged.
- Not defined:
  - The z_comb port does not exist.
  - The block is fully registered.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs and in_valid=1 -> z=4'h0, sel_q=0, out_valid=0.
- Sweep sel: i1=4'h3, i2=4'hA, i3=4'h5, i4=4'hC, in_valid=1, sel stepping 0,1,2,3 on consecutive cycles -> z=3, A, 5, C respectively one cycle later; sel_q tracks 0..3; out_valid=1 each cycle.
- Hold: capture sel=2, i3=4'h9, then drop in_valid and change all inputs to 4'hF -> z stays 4'h9, sel_q stays 2, out_valid=0.
- Random: 1000 cycles of random i1..i4 and sel with random in_valid -> on every in_valid cycle, z next cycle equals the reference-model selection.
- Reset mid-stream: in_valid=1, sel=3, i4=4'h7 asserted together with rst=1 -> next cycle z=0, out_valid=0.
- With MUX41_COMB_OUT_EN defined: sel=1, i2=4'hB -> z_comb=4'hB in the same cycle; z=4'hB only after the next edge if in_valid=1.
